ens0_layer2_out_stage: RTL and testbench

Pipeline boundary stage that sits directly downstream of the ens0 layer-2 neuron LUTs. It captures the full layer-2 output bit-vector, one bit per neuron. It presents that vector to the next layer through a valid/ready handshake, with a 2-entry skid buffer so back-pressure never drops a sample. It also carries a per-sample tag, counts accepted samples, and flags tag-sequence breaks for debug.

---
 rtl/ens0_layer2_out_stage.sv | 115 +++++++++++
 tb/tb_ens0_layer2_out_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ens0_layer2_out_stage.sv
// Layer-2 output boundary stage: captures the neuron output vector and its tag behind a
// valid/ready handshake with a 2-entry skid buffer, plus an accept counter and tag-sequence check.
module ens0_layer2_out_stage #(
   parameter int unsigned OUT_WIDTH = 64,
   parameter int unsigned TAG_WIDTH = 16,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [OUT_WIDTH-1:0] s_data,
   input  logic [TAG_WIDTH-1:0] s_tag,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic [TAG_WIDTH-1:0] m_tag,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] sample_count,
   output logic                 seq_err
);

   // Encoding doubles as the occupancy value.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e               r_state;
   logic [OUT_WIDTH-1:0] r_main_data;
   logic [TAG_WIDTH-1:0] r_main_tag;
   logic [OUT_WIDTH-1:0] r_skid_data;
   logic [TAG_WIDTH-1:0] r_skid_tag;
   logic [CNT_WIDTH-1:0] r_count;
   logic [TAG_WIDTH-1:0] r_last_tag;
   logic                 r_have_tag;
   logic                 r_seq_err;

   logic                 w_push;
   logic                 w_pop;
   logic [TAG_WIDTH-1:0] w_tag_next;

   // s_ready depends only on registered state and flush, never on m_ready.
   assign s_ready      = (r_state != StFull) && !flush;
   assign m_valid      = (r_state != StEmpty);
   assign w_push       = s_valid && s_ready;
   assign w_pop        = m_valid && m_ready;
   assign w_tag_next   = r_last_tag + TAG_WIDTH'(1);

   assign m_data       = r_main_data;
   assign m_tag        = r_main_tag;
   assign occupancy    = r_state;
   assign sample_count = r_count;
   assign seq_err      = r_seq_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StEmpty;
         r_main_data <= '0;
         r_main_tag  <= '0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
         r_count     <= '0;
         r_last_tag  <= '0;
         r_have_tag  <= 1'b0;
         r_seq_err   <= 1'b0;
      end else begin
         if (w_push) begin
            r_count    <= r_count + CNT_WIDTH'(1);
            r_last_tag <= s_tag;
            r_have_tag <= 1'b1;
            if (r_have_tag && (s_tag != w_tag_next)) begin
               r_seq_err <= 1'b1;
            end
         end

         if (flush) begin
            r_state <= StEmpty;
         end else begin
            case (r_state)
               StEmpty: begin
                  if (w_push) begin
                     r_main_data <= s_data;
                     r_main_tag  <= s_tag;
                     r_state     <= StOne;
                  end
               end
               StOne: begin
                  if (w_push && w_pop) begin
                     r_main_data <= s_data;
                     r_main_tag  <= s_tag;
                  end else if (w_push) begin
                     r_skid_data <= s_data;
                     r_skid_tag  <= s_tag;
                     r_state     <= StFull;
                  end else if (w_pop) begin
                     r_state <= StEmpty;
                  end
               end
               StFull: begin
                  if (w_pop) begin
                     r_main_data <= r_skid_data;
                     r_main_tag  <= r_skid_tag;
                     r_state     <= StOne;
                  end
               end
               default: r_state <= StEmpty;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ens0_layer2_out_stage.sv
// Bench for ens0_layer2_out_stage: directed vector table, hand sequences for tags/reset,
// and randomized traffic checked against a queue-based reference model.
module tb_ens0_layer2_out_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] s_data = '0;
   logic [15:0] s_tag = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [63:0] m_data;
   logic [15:0] m_tag;
   logic [1:0]  occupancy;
   logic [31:0] sample_count;
   logic        seq_err;

   always #5 clk = ~clk;

   ens0_layer2_out_stage dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_tag        (s_tag),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_tag        (m_tag),
      .occupancy    (occupancy),
      .sample_count (sample_count),
      .seq_err      (seq_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a FIFO of at most two samples plus accept counter and tag tracker.
   typedef struct packed {
      logic [63:0] d;
      logic [15:0] t;
   } smp_t;
   smp_t        mq[$];
   logic [31:0] m_cnt;
   logic        m_seq_err;
   logic        m_have;
   logic [15:0] m_last;

   typedef struct {
      logic        sv;
      logic        mr;
      logic        fl;
      logic [15:0] tag;
      logic        exp_sready;
      logic        exp_mvalid;
      logic [1:0]  exp_occ;
      logic [15:0] exp_mtag;
      logic [31:0] exp_cnt;
   } vec_t;
   vec_t tbl[9];

   function automatic logic [63:0] rep(input logic [15:0] t);
      return {4{t}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_cnt     = '0;
      m_seq_err = 1'b0;
      m_have    = 1'b0;
      m_last    = '0;
   endtask

   task automatic check_outputs();
      chk("m_valid", m_valid, mq.size() > 0);
      chk("occupancy", occupancy, 64'(mq.size()));
      if (mq.size() > 0) begin
         chk("m_data", m_data, mq[0].d);
         chk("m_tag", m_tag, mq[0].t);
      end
      chk("sample_count", sample_count, m_cnt);
      chk("seq_err", seq_err, m_seq_err);
   endtask

   // Called just after a falling edge; applies inputs for one cycle and checks the result.
   task automatic step(input logic sv, input logic [15:0] tag, input logic [63:0] data,
                       input logic mr, input logic fl, output logic sready_seen);
      logic        push;
      logic        pop;
      logic [15:0] nxt;
      smp_t        s;
      s_valid = sv;
      s_tag   = tag;
      s_data  = data;
      m_ready = mr;
      flush   = fl;
      #1;
      sready_seen = s_ready;
      chk("s_ready", s_ready, (mq.size() < 2) && !fl);
      push = sv && (mq.size() < 2) && !fl;
      pop  = (mq.size() > 0) && mr;
      @(posedge clk);
      if (push) begin
         nxt = m_last + 16'd1;
         m_cnt = m_cnt + 32'd1;
         if (m_have && (tag != nxt)) m_seq_err = 1'b1;
         m_last = tag;
         m_have = 1'b1;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            s.d = data;
            s.t = tag;
            mq.push_back(s);
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      flush   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_tag", m_tag, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_sample_count", sample_count, 0);
      chk("rst_seq_err", seq_err, 0);
      rst = 1'b0;
      model_clear();
      #1;
      chk("rst_s_ready", s_ready, 1);
   endtask

   initial begin
      logic        sr;
      logic [15:0] rt;
      logic        sv;
      logic        mr;
      logic        fl;

      // Skid fill/drain, simultaneous push/pop in ONE, then flush while FULL.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 16'd5,  1'b1, 1'b1, 2'd1, 16'd5, 32'd1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 16'd6,  1'b1, 1'b1, 2'd2, 16'd5, 32'd2};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 2'd2, 16'd5, 32'd2};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 16'd0,  1'b0, 1'b1, 2'd1, 16'd6, 32'd2};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 2'd0, 16'd0, 32'd2};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 16'd7,  1'b1, 1'b1, 2'd1, 16'd7, 32'd3};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 16'd8,  1'b1, 1'b1, 2'd1, 16'd8, 32'd4};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 16'd9,  1'b1, 1'b1, 2'd2, 16'd8, 32'd5};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 2'd0, 16'd0, 32'd5};

      model_clear();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].sv, tbl[i].tag, rep(tbl[i].tag), tbl[i].mr, tbl[i].fl, sr);
         chk("tbl_s_ready", sr, tbl[i].exp_sready);
         chk("tbl_m_valid", m_valid, tbl[i].exp_mvalid);
         chk("tbl_occupancy", occupancy, tbl[i].exp_occ);
         if (tbl[i].exp_mvalid) begin
            chk("tbl_m_tag", m_tag, tbl[i].exp_mtag);
            chk("tbl_m_data", m_data, rep(tbl[i].exp_mtag));
         end
         chk("tbl_count", sample_count, tbl[i].exp_cnt);
      end
      chk("tbl_seq_err", seq_err, 0);

      // Streaming without back-pressure.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'(i), rep(16'(i)), 1'b1, 1'b0, sr);
         chk("stream_occ_le1", occupancy <= 2'd1, 1);
      end
      chk("stream_count", sample_count, 10);
      chk("stream_seq_err", seq_err, 0);

      // Tag wrap is legal; a jump is sticky.
      do_reset();
      step(1'b1, 16'hFFFE, rep(16'hFFFE), 1'b1, 1'b0, sr);
      step(1'b1, 16'hFFFF, rep(16'hFFFF), 1'b1, 1'b0, sr);
      step(1'b1, 16'h0000, rep(16'h0000), 1'b1, 1'b0, sr);
      chk("wrap_seq_err", seq_err, 0);
      step(1'b1, 16'h0005, rep(16'h0005), 1'b1, 1'b0, sr);
      chk("jump_seq_err", seq_err, 1);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 16'(6 + i), rep(16'(6 + i)), 1'b1, 1'b0, sr);
      end
      chk("sticky_seq_err", seq_err, 1);
      chk("sticky_count", sample_count, 104);

      // Reset while FULL with a flagged error.
      do_reset();
      for (int i = 0; i < 35; i++) begin
         step(1'b1, 16'(i), rep(16'(i)), 1'b1, 1'b0, sr);
      end
      step(1'b1, 16'd50, rep(16'd50), 1'b1, 1'b0, sr);
      step(1'b1, 16'd51, rep(16'd51), 1'b0, 1'b0, sr);
      chk("pre_rst_occ", occupancy, 2);
      chk("pre_rst_count", sample_count, 37);
      chk("pre_rst_seq_err", seq_err, 1);
      do_reset();
      step(1'b1, 16'h1234, rep(16'h1234), 1'b1, 1'b0, sr);
      chk("post_rst_seq_err", seq_err, 0);
      chk("post_rst_m_tag", m_tag, 16'h1234);

      // Randomized traffic against the model.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         rt = 16'($urandom);
         for (int i = 0; i < 400; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) rt = 16'($urandom);
            step(sv, rt, {$urandom, $urandom}, mr, fl, sr);
            if (sv && sr) rt = rt + 16'd1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
